align_stage: RTL
================

ALIGN_STAGE -- requirements
Module: align_stage

Interface
REQ-001 SHALL have parameter EXT_W, default 3, number of extension bits (guard, round, sticky) below the 24-bit mantissa; only 3 is supported.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  upstream operand pair valid.
REQ-005 SHALL have port ready_o  output  1  stage can accept the operand pair this cycle.
REQ-006 SHALL have port a_i  input  float_point_num  operand A, hidden bit already inserted in mant[23].
REQ-007 SHALL have port b_i  input  float_point_num  operand B, same format as a_i.
REQ-008 SHALL have port num_status_i  input  2  ZERO_res / INF_OR_NAN / OK_state classification from the fetch stage.
REQ-009 SHALL have port valid_o  output  1  aligned result valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port sign_big_o / sign_small_o  output  1 each  signs of the larger and smaller magnitude operands.
REQ-012 SHALL have port exp_o  output  8  common (larger) exponent.
REQ-013 SHALL have port mant_big_o  output  27  {larger mant, 3'b0}.
REQ-014 SHALL have port mant_small_o  output  27  smaller mant aligned, with G/R/S in bits [2:0].
REQ-015 SHALL have port eff_sub_o  output  1  a_i.sign XOR b_i.sign.
REQ-016 SHALL have port swapped_o  output  1  B was selected as the larger operand.
REQ-017 SHALL have port num_status_o  output  2  num_status_i, registered unchanged.

Function
REQ-018 SHALL use a single output register stage; latency valid_i-accept to valid_o = 1 cycle.
REQ-019 SHALL drive ready_o = ~valid_o | ready_i (combinational).
REQ-020 SHALL accept (load the output register) only when valid_i & ready_o.
REQ-021 SHALL clear valid_o when ready_i & valid_o and no new transfer occurs in the same cycle.
REQ-022 SHALL hold all outputs stable while valid_o & ~ready_i; valid_i is ignored in that state.
REQ-023 SHALL sustain one transfer per cycle when valid_i and ready_i are continuously high (simultaneous drain and load).
REQ-024 SHALL select A as larger when a_i.exp > b_i.exp, or exps equal and a_i.mant >= b_i.mant; otherwise B, with swapped_o=1.
REQ-025 SHALL compute the 8-bit unsigned shift d = exp_big - exp_small.
REQ-026 SHALL form mant_small_o = ({mant_small,3'b0} >> d), with bit0 ORed with OR of all bits shifted out.
REQ-027 SHALL, for d >= 27, output mant_small_o = {26'b0, |mant_small}.
REQ-028 SHALL compute data regardless of num_status_i; status interpretation is downstream.
REQ-029 SHALL hold output registers unchanged in cycles with no transfer.

Reset
REQ-030 SHALL, on rst_i high at a clock edge, set valid_o=0 and all data outputs and num_status_o to 0, taking priority over any transfer.
REQ-031 SHALL drop an in-flight or stalled result on reset mid-operation; no result is emitted for it.
REQ-032 SHALL drive ready_o=1 in the first cycle after reset.

Verification
REQ-033 SHALL cover: a={0,127,0x800000}, b={0,126,0x800000}, OK -> next cycle valid_o=1, exp_o=127, mant_big_o=0x4000000, mant_small_o=0x2000000, swapped_o=0, eff_sub_o=0.
REQ-034 SHALL cover: a={1,126,0x800000}, b={0,127,0x800000} -> swapped_o=1, sign_big_o=0, sign_small_o=1, eff_sub_o=1, exp_o=127.
REQ-035 SHALL cover: d=5, small mant 0x800001 -> mant_small_o=0x0200001 (sticky set); d=30, small mant 0x800001 -> mant_small_o=0x0000001.
REQ-036 SHALL cover: valid_o=1, ready_i=0 for 3 cycles with new valid_i -> ready_o=0, outputs unchanged; ready_i=1 -> pending pair loaded next cycle, no loss or duplication.
REQ-037 SHALL cover: num_status_i=INF_OR_NAN (a.exp=255) -> num_status_o=INF_OR_NAN one cycle later.
REQ-038 SHALL cover: rst_i asserted while valid_o=1, ready_i=0 -> next cycle valid_o=0, all outputs 0, ready_o=1.

Source files
------------

// File: rtl/align_stage.sv
// align_stage: exponent-compare / mantissa-align stage of a single-precision
// adder. Orders the operand pair by magnitude, shifts the smaller mantissa
// right by the exponent difference (keeping guard/round/sticky), and presents
// the result through one output register with a valid/ready handshake.
//
// Operand packing on a_i / b_i (33 bits, hidden bit already inserted):
//   [32]    sign
//   [31:24] exponent
//   [23:0]  mantissa, mant[23] is the hidden bit
//
// Handshake: a pair transfers in when valid_i & ready_o at a rising edge; a
// result transfers out when valid_o & ready_i at a rising edge. ready_o is
// ~valid_o | ready_i, so a full register drains and refills in the same cycle
// and sustains one transfer per cycle. While valid_o & ~ready_i, all outputs
// are held and valid_i is ignored.
//
// num_status_i is carried alongside the data untouched; the data path is
// computed the same way for every status, the next stage interprets it.
module align_stage #(
  parameter int EXT_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  input  logic [1:0]  num_status_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sign_big_o,
  output logic        sign_small_o,
  output logic [7:0]  exp_o,
  output logic [26:0] mant_big_o,
  output logic [26:0] mant_small_o,
  output logic        eff_sub_o,
  output logic        swapped_o,
  output logic [1:0]  num_status_o
);

  localparam int MW = 24;
  localparam int AW = MW + EXT_W;
  localparam logic [7:0] AW_D = 8'(AW);

  // Operand fields
  logic          w_a_sign;
  logic [7:0]    w_a_exp;
  logic [MW-1:0] w_a_mant;
  logic          w_b_sign;
  logic [7:0]    w_b_exp;
  logic [MW-1:0] w_b_mant;

  // Ordered operands
  logic          w_a_big;
  logic          w_sign_big;
  logic          w_sign_small;
  logic [7:0]    w_exp_big;
  logic [7:0]    w_exp_small;
  logic [MW-1:0] w_mant_big;
  logic [MW-1:0] w_mant_small;
  logic [7:0]    w_d;

  // Alignment
  logic [AW-1:0] w_ext_small;
  logic [AW-1:0] w_shifted;
  logic [AW-1:0] w_mask;
  logic          w_sticky;
  logic [AW-1:0] w_aligned;

  logic          w_load;

  // Output register
  logic          r_valid;
  logic          r_sign_big;
  logic          r_sign_small;
  logic [7:0]    r_exp;
  logic [AW-1:0] r_mant_big;
  logic [AW-1:0] r_mant_small;
  logic          r_eff_sub;
  logic          r_swapped;
  logic [1:0]    r_status;

  assign w_a_sign = a_i[32];
  assign w_a_exp  = a_i[31:24];
  assign w_a_mant = a_i[23:0];
  assign w_b_sign = b_i[32];
  assign w_b_exp  = b_i[31:24];
  assign w_b_mant = b_i[23:0];

  assign ready_o = ~r_valid | ready_i;
  assign w_load  = valid_i & ready_o;

  // Pick the larger-magnitude operand; ties on exponent go to A when its
  // mantissa is not smaller, so equal magnitudes never report a swap.
  always_comb begin
    w_a_big      = 1'b0;
    w_sign_big   = 1'b0;
    w_sign_small = 1'b0;
    w_exp_big    = '0;
    w_exp_small  = '0;
    w_mant_big   = '0;
    w_mant_small = '0;
    if (w_a_exp > w_b_exp) begin
      w_a_big = 1'b1;
    end else if ((w_a_exp == w_b_exp) && (w_a_mant >= w_b_mant)) begin
      w_a_big = 1'b1;
    end
    if (w_a_big) begin
      w_sign_big   = w_a_sign;
      w_sign_small = w_b_sign;
      w_exp_big    = w_a_exp;
      w_exp_small  = w_b_exp;
      w_mant_big   = w_a_mant;
      w_mant_small = w_b_mant;
    end else begin
      w_sign_big   = w_b_sign;
      w_sign_small = w_a_sign;
      w_exp_big    = w_b_exp;
      w_exp_small  = w_a_exp;
      w_mant_big   = w_b_mant;
      w_mant_small = w_a_mant;
    end
  end

  assign w_d = w_exp_big - w_exp_small;

  // Right-shift the extended smaller mantissa; every bit that falls off the
  // bottom is folded into the sticky position. Shifts of the full width or
  // more leave only the sticky bit.
  always_comb begin
    w_ext_small = {w_mant_small, {EXT_W{1'b0}}};
    w_shifted   = '0;
    w_mask      = '0;
    w_sticky    = 1'b0;
    w_aligned   = '0;
    if (w_d >= AW_D) begin
      w_aligned = {{(AW-1){1'b0}}, |w_mant_small};
    end else begin
      w_shifted = w_ext_small >> w_d;
      w_mask    = ({{(AW-1){1'b0}}, 1'b1} << w_d) - {{(AW-1){1'b0}}, 1'b1};
      w_sticky  = |(w_ext_small & w_mask);
      w_aligned = {w_shifted[AW-1:1], w_shifted[0] | w_sticky};
    end
  end

  // Output register: reset wins, then load on accept, else drain on consume.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_exp        <= '0;
      r_mant_big   <= '0;
      r_mant_small <= '0;
      r_eff_sub    <= 1'b0;
      r_swapped    <= 1'b0;
      r_status     <= '0;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_sign_big   <= w_sign_big;
      r_sign_small <= w_sign_small;
      r_exp        <= w_exp_big;
      r_mant_big   <= {w_mant_big, {EXT_W{1'b0}}};
      r_mant_small <= w_aligned;
      r_eff_sub    <= w_a_sign ^ w_b_sign;
      r_swapped    <= ~w_a_big;
      r_status     <= num_status_i;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o      = r_valid;
  assign sign_big_o   = r_sign_big;
  assign sign_small_o = r_sign_small;
  assign exp_o        = r_exp;
  assign mant_big_o   = r_mant_big;
  assign mant_small_o = r_mant_small;
  assign eff_sub_o    = r_eff_sub;
  assign swapped_o    = r_swapped;
  assign num_status_o = r_status;

endmodule
